// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use, mul/div, branch flush and memory freeze.
// Drives PC / pipeline-register enables and keeps saturating perf counters.
module hazard_control_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead_E,
    input  logic [REG_AW-1:0] Rd_E,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic              Use_Rs1_D,
    input  logic              Use_Rs2_D,
    input  logic              MulDiv_Start_E,
    input  logic              MulDiv_Done,
    input  logic              BranchTaken_E,
    input  logic              DMemReq_M,
    input  logic              DMemReady_M,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              ID_EX_Write,
    output logic              EX_MEM_Write,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Flush,
    output logic              EX_MEM_Flush,
    output logic              MEM_WB_Flush,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MD_BUSY  = 2'd2
    } state_t;

    localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

    state_t     state, state_nx;
    logic [2:0] lu_cnt, lu_cnt_nx;
    logic       lu_hit;
    logic       freeze;
    logic       md_stall;
    logic       flush_inc;

    assign lu_hit = MemRead_E && (Rd_E != '0) &&
                    ((Use_Rs1_D && (Rd_E == Rs1_D)) ||
                     (Use_Rs2_D && (Rd_E == Rs2_D)));
    assign freeze   = DMemReq_M && !DMemReady_M;
    assign md_stall = (state == MD_BUSY) ||
                      ((state == RUN) && MulDiv_Start_E && !MulDiv_Done);
    assign state_o  = state;

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        MEM_WB_Flush = 1'b0;
        state_nx     = state;
        lu_cnt_nx    = lu_cnt;
        flush_inc    = 1'b0;
        if (reset) begin
            state_nx = RUN;
        end else if (freeze) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Flush = 1'b1;
        end else if (md_stall) begin
            if ((state == MD_BUSY) && MulDiv_Done) begin
                state_nx = RUN;
            end else begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Write  = 1'b0;
                EX_MEM_Flush = 1'b1;
                state_nx     = MD_BUSY;
            end
        end else if ((state == RUN) && BranchTaken_E) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            flush_inc   = 1'b1;
        end else if ((state == RUN) && lu_hit) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            if (LOAD_LAT > 1) begin
                state_nx  = LU_STALL;
                lu_cnt_nx = LU_INIT;
            end
        end else if (state == LU_STALL) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            lu_cnt_nx   = lu_cnt - 3'd1;
            // lu_cnt of 1 marks the final stall cycle
            if (lu_cnt <= 3'd1) begin
                state_nx  = RUN;
                lu_cnt_nx = 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            lu_cnt       <= 3'd0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state  <= state_nx;
            lu_cnt <= lu_cnt_nx;
            if (!PCWrite && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush_inc && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized scoreboard bench for hazard_control_unit, two configurations
// (LOAD_LAT=1/CNT_W=32 and LOAD_LAT=3/CNT_W=5) driven by the same stimulus.
module tb_hazard_control_unit;

    typedef struct {
        bit       reset;
        bit       mem_read;
        bit [4:0] rd, rs1, rs2;
        bit       use1, use2, start, done, br, req, rdy;
    } stim_t;

    typedef struct {
        logic [7:0]  ctl;
        logic [1:0]  st;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    typedef struct {
        bit     md;
        int     lu_left;
        longint stall;
        longint flush;
    } mstate_t;

    // {PCWrite,IF_ID_W,ID_EX_W,EX_MEM_W,IF_ID_F,ID_EX_F,EX_MEM_F,MEM_WB_F}
    localparam logic [7:0] C_DEF = 8'b1111_0000;
    localparam logic [7:0] C_FRZ = 8'b0000_0001;
    localparam logic [7:0] C_MD  = 8'b0001_0010;
    localparam logic [7:0] C_BR  = 8'b1111_1100;
    localparam logic [7:0] C_LU  = 8'b0011_0100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic MemRead_E = 0, Use_Rs1_D = 0, Use_Rs2_D = 0;
    logic [4:0] Rd_E = 0, Rs1_D = 0, Rs2_D = 0;
    logic MulDiv_Start_E = 0, MulDiv_Done = 0, BranchTaken_E = 0;
    logic DMemReq_M = 0, DMemReady_M = 0;

    wire [7:0]  ctl_a, ctl_b;
    wire [31:0] sc_a, fc_a;
    wire [4:0]  sc_b, fc_b;
    wire [1:0]  st_a, st_b;

    exp_t    qa[$], qb[$];
    mstate_t ma, mb;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .MemRead_E(MemRead_E), .Rd_E(Rd_E),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Use_Rs1_D(Use_Rs1_D),
        .Use_Rs2_D(Use_Rs2_D), .MulDiv_Start_E(MulDiv_Start_E),
        .MulDiv_Done(MulDiv_Done), .BranchTaken_E(BranchTaken_E),
        .DMemReq_M(DMemReq_M), .DMemReady_M(DMemReady_M),
        .PCWrite(ctl_a[7]), .IF_ID_Write(ctl_a[6]), .ID_EX_Write(ctl_a[5]),
        .EX_MEM_Write(ctl_a[4]), .IF_ID_Flush(ctl_a[3]),
        .ID_EX_Flush(ctl_a[2]), .EX_MEM_Flush(ctl_a[1]),
        .MEM_WB_Flush(ctl_a[0]), .stall_cycles(sc_a), .flush_count(fc_a),
        .state_o(st_a)
    );

    hazard_control_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(5)) dut_b (
        .clk(clk), .reset(reset), .MemRead_E(MemRead_E), .Rd_E(Rd_E),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Use_Rs1_D(Use_Rs1_D),
        .Use_Rs2_D(Use_Rs2_D), .MulDiv_Start_E(MulDiv_Start_E),
        .MulDiv_Done(MulDiv_Done), .BranchTaken_E(BranchTaken_E),
        .DMemReq_M(DMemReq_M), .DMemReady_M(DMemReady_M),
        .PCWrite(ctl_b[7]), .IF_ID_Write(ctl_b[6]), .ID_EX_Write(ctl_b[5]),
        .EX_MEM_Write(ctl_b[4]), .IF_ID_Flush(ctl_b[3]),
        .ID_EX_Flush(ctl_b[2]), .EX_MEM_Flush(ctl_b[1]),
        .MEM_WB_Flush(ctl_b[0]), .stall_cycles(sc_b), .flush_count(fc_b),
        .state_o(st_b)
    );

    // Reference: md = mul/div outstanding, lu_left = stall cycles still owed
    function automatic void step(input stim_t s, input int lat, input int w,
                                 inout mstate_t m, output exp_t e);
        bit     hit;
        longint mx;
        hit = s.mem_read && s.rd != 0 &&
              ((s.use1 && s.rd == s.rs1) || (s.use2 && s.rd == s.rs2));
        mx = (longint'(1) << w) - 1;
        e.st = m.md ? 2'd2 : (m.lu_left > 0 ? 2'd1 : 2'd0);
        e.sc = 32'(m.stall);
        e.fc = 32'(m.flush);
        e.ctl = C_DEF;
        if (s.reset) begin
            m.md = 0;
            m.lu_left = 0;
            m.stall = 0;
            m.flush = 0;
        end else begin
            if (s.req && !s.rdy) begin
                e.ctl = C_FRZ;
            end else if (m.md) begin
                if (s.done) m.md = 0;
                else e.ctl = C_MD;
            end else if (m.lu_left > 0) begin
                e.ctl = C_LU;
                m.lu_left--;
            end else if (s.start && !s.done) begin
                e.ctl = C_MD;
                m.md = 1;
            end else if (s.br) begin
                e.ctl = C_BR;
                if (m.flush < mx) m.flush++;
            end else if (hit) begin
                e.ctl = C_LU;
                m.lu_left = lat - 1;
            end
            if (!e.ctl[7] && m.stall < mx) m.stall++;
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t lw_hazard();
        stim_t s;
        s = idle();
        s.mem_read = 1;
        s.rd = 5;
        s.rs1 = 5;
        s.use1 = 1;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        exp_t ea, eb;
        reset = s.reset;
        MemRead_E = s.mem_read;
        Rd_E = s.rd;
        Rs1_D = s.rs1;
        Rs2_D = s.rs2;
        Use_Rs1_D = s.use1;
        Use_Rs2_D = s.use2;
        MulDiv_Start_E = s.start;
        MulDiv_Done = s.done;
        BranchTaken_E = s.br;
        DMemReq_M = s.req;
        DMemReady_M = s.rdy;
        step(s, 1, 32, ma, ea);
        step(s, 3, 5, mb, eb);
        qa.push_back(ea);
        qb.push_back(eb);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("A ctl", {24'd0, ctl_a}, {24'd0, e.ctl});
            chk("A state", {30'd0, st_a}, {30'd0, e.st});
            chk("A stall_cycles", sc_a, e.sc);
            chk("A flush_count", fc_a, e.fc);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("B ctl", {24'd0, ctl_b}, {24'd0, e.ctl});
            chk("B state", {30'd0, st_b}, {30'd0, e.st});
            chk("B stall_cycles", {27'd0, sc_b}, e.sc);
            chk("B flush_count", {27'd0, fc_b}, e.fc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        ma = '{default: 0};
        mb = '{default: 0};
        @(posedge clk);
        #1;
        s = idle();
        s.reset = 1;
        drive(s);
        drive(s);
        // single load-use hazard, then idle
        drive(lw_hazard());
        repeat (4) drive(idle());
        // held hazard with a two-cycle memory wait in the middle
        s = lw_hazard();
        drive(s);
        s.req = 1;
        drive(s);
        drive(s);
        s.req = 0;
        drive(s);
        drive(s);
        repeat (3) drive(idle());
        // no hazard: x0 destination, and Rs2 match without Use_Rs2_D
        s = lw_hazard();
        s.rd = 0;
        s.rs1 = 0;
        drive(s);
        s = idle();
        s.mem_read = 1;
        s.rd = 7;
        s.rs2 = 7;
        drive(s);
        drive(idle());
        // taken branch wins over a simultaneous load-use hit
        s = lw_hazard();
        s.br = 1;
        drive(s);
        drive(idle());
        // mul/div done four cycles after start
        s = idle();
        s.start = 1;
        drive(s);
        repeat (3) drive(idle());
        s = idle();
        s.done = 1;
        drive(s);
        drive(idle());
        // reset while mul/div busy
        s = idle();
        s.start = 1;
        drive(s);
        repeat (2) drive(idle());
        s = idle();
        s.reset = 1;
        drive(s);
        repeat (2) drive(idle());
        // long freeze and branch runs push the 5-bit counters to saturation
        s = idle();
        s.req = 1;
        repeat (40) drive(s);
        s = idle();
        s.br = 1;
        repeat (40) drive(s);
        for (int i = 0; i < 3000; i++) begin
            s.reset    = ($urandom_range(0, 99) < 1);
            s.mem_read = 1'($urandom_range(0, 1));
            s.rd       = 5'($urandom_range(0, 3));
            s.rs1      = 5'($urandom_range(0, 3));
            s.rs2      = 5'($urandom_range(0, 3));
            s.use1     = 1'($urandom_range(0, 1));
            s.use2     = 1'($urandom_range(0, 1));
            s.start    = ($urandom_range(0, 99) < 10);
            s.done     = ($urandom_range(0, 99) < 30);
            s.br       = ($urandom_range(0, 99) < 15);
            s.req      = ($urandom_range(0, 99) < 40);
            s.rdy      = 1'($urandom_range(0, 1));
            drive(s);
        end
        drive(idle());
        @(negedge clk);
        #1;
        chk("scoreboard A drained", qa.size(), 0);
        chk("scoreboard B drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
